// File: rtl/fetch_stage.sv
// Instruction-fetch stage: drives instruction memory from the current PC,
// loads the IF/ID pipeline register, and gates the PC write enable.
// A one-entry hold buffer absorbs a fetched word while decode is stalled.
// Optional macro FETCH_PERF_EN adds fetch_count / wait_cycles counters.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0040_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc,
  output logic        pc_we,
  output logic [31:0] pc_plus4,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  input  logic        id_stall,
  input  logic        flush,
  output logic        if_id_valid,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_pc_plus4
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] fetch_count,
  output logic [31:0] wait_cycles
`endif
);

  typedef enum logic [0:0] {StFetch, StHold} state_e;

  state_e      state_q, state_d;
  logic        valid_q, valid_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] ipc_q, ipc_d;
  logic [31:0] ipc4_q, ipc4_d;
  logic [31:0] hold_instr_q, hold_instr_d;
  logic [31:0] hold_pc_q, hold_pc_d;
  logic [31:0] hold_pc4_q, hold_pc4_d;
  logic        can_load;
  logic        accept;

  assign pc_plus4  = pc + 32'd4;
  assign imem_addr = pc;

  // A stall only blocks IF/ID when it actually holds an instruction.
  assign can_load = !(id_stall && valid_q);

  // Next-state, IF/ID / hold-buffer updates and PC/imem handshake outputs.
  always_comb begin
    state_d      = state_q;
    valid_d      = valid_q;
    instr_d      = instr_q;
    ipc_d        = ipc_q;
    ipc4_d       = ipc4_q;
    hold_instr_d = hold_instr_q;
    hold_pc_d    = hold_pc_q;
    hold_pc4_d   = hold_pc4_q;
    pc_we        = 1'b0;
    imem_req     = 1'b0;
    accept       = 1'b0;
    if (!reset) begin
      unique case (state_q)
        StFetch: begin
          imem_req = 1'b1;
          if (flush) begin
            // Redirect: the in-flight word is dropped, memory restarts at the new PC.
            pc_we   = 1'b1;
            valid_d = 1'b0;
          end else if (imem_ready) begin
            pc_we  = 1'b1;
            accept = 1'b1;
            if (can_load) begin
              valid_d = 1'b1;
              instr_d = imem_rdata;
              ipc_d   = pc;
              ipc4_d  = pc_plus4;
            end else begin
              hold_instr_d = imem_rdata;
              hold_pc_d    = pc;
              hold_pc4_d   = pc_plus4;
              state_d      = StHold;
            end
          end else if (can_load) begin
            valid_d = 1'b0;
          end
        end
        StHold: begin
          if (flush) begin
            pc_we   = 1'b1;
            valid_d = 1'b0;
            state_d = StFetch;
          end else if (!id_stall) begin
            valid_d = 1'b1;
            instr_d = hold_instr_q;
            ipc_d   = hold_pc_q;
            ipc4_d  = hold_pc4_q;
            state_d = StFetch;
          end
        end
      endcase
    end
  end

  // State, IF/ID register and hold buffer.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StFetch;
      valid_q      <= 1'b0;
      instr_q      <= NOP_INSTR;
      ipc_q        <= RESET_PC;
      ipc4_q       <= RESET_PC + 32'd4;
      hold_instr_q <= '0;
      hold_pc_q    <= '0;
      hold_pc4_q   <= '0;
    end else begin
      state_q      <= state_d;
      valid_q      <= valid_d;
      instr_q      <= instr_d;
      ipc_q        <= ipc_d;
      ipc4_q       <= ipc4_d;
      hold_instr_q <= hold_instr_d;
      hold_pc_q    <= hold_pc_d;
      hold_pc4_q   <= hold_pc4_d;
    end
  end

  assign if_id_valid    = valid_q;
  assign if_id_instr    = valid_q ? instr_q : NOP_INSTR;
  assign if_id_pc       = ipc_q;
  assign if_id_pc_plus4 = ipc4_q;

`ifdef FETCH_PERF_EN
  logic [31:0] fetch_count_q;
  logic [31:0] wait_cycles_q;

  // Performance counters: accepted fetches and memory wait cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_count_q <= '0;
      wait_cycles_q <= '0;
    end else begin
      if (accept) begin
        fetch_count_q <= fetch_count_q + 32'd1;
      end
      if (imem_req && !imem_ready) begin
        wait_cycles_q <= wait_cycles_q + 32'd1;
      end
    end
  end

  assign fetch_count = fetch_count_q;
  assign wait_cycles = wait_cycles_q;
`else
  logic unused_accept;
  assign unused_accept = accept;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: a PC/memory environment plus an in-order
// scoreboard of words the memory returned, compared as decode consumes them.
module tb_fetch_stage;

  localparam logic [31:0] ResetPc = 32'h0040_0000;
  localparam logic [31:0] NopInstr = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc;
  logic        pc_we;
  logic [31:0] pc_plus4;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        id_stall;
  logic        flush;
  logic        if_id_valid;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_pc_plus4;
`ifdef FETCH_PERF_EN
  logic [31:0] fetch_count;
  logic [31:0] wait_cycles;
`endif

  logic        rdy_en;
  logic [31:0] flush_tgt;
  int          n_checks = 0;
  int          n_fail = 0;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } sb_t;
  sb_t sb_q[$];

  fetch_stage #(
    .RESET_PC (ResetPc),
    .NOP_INSTR(NopInstr)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .pc            (pc),
    .pc_we         (pc_we),
    .pc_plus4      (pc_plus4),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ready    (imem_ready),
    .imem_rdata    (imem_rdata),
    .id_stall      (id_stall),
    .flush         (flush),
    .if_id_valid   (if_id_valid),
    .if_id_instr   (if_id_instr),
    .if_id_pc      (if_id_pc),
    .if_id_pc_plus4(if_id_pc_plus4)
`ifdef FETCH_PERF_EN
    ,
    .fetch_count   (fetch_count),
    .wait_cycles   (wait_cycles)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h2048_0005;
  endfunction

  // Memory only answers an active request.
  assign imem_ready = rdy_en && imem_req;
  assign imem_rdata = mem_word(imem_addr);

  // Program counter environment.
  always @(posedge clk) begin
    if (reset) begin
      pc <= ResetPc;
    end else if (pc_we) begin
      pc <= flush ? flush_tgt : pc + 32'd4;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive inputs, then at the falling edge consume/record scoreboard entries.
  task automatic sample(input logic st, input logic fl, input logic rd);
    sb_t e;
    id_stall = st;
    flush    = fl;
    rdy_en   = rd;
    @(negedge clk);
    if (reset) begin
      sb_q.delete();
    end else begin
      if (if_id_valid && !id_stall) begin
        if (sb_q.size() == 0) begin
          check("sb_unexpected_word", if_id_pc, 32'hxxxx_xxxx);
        end else begin
          e = sb_q.pop_front();
          check("sb_instr", if_id_instr, e.instr);
          check("sb_pc", if_id_pc, e.pc);
          check("sb_pc4", if_id_pc_plus4, e.pc + 32'd4);
        end
      end
      if (flush) begin
        sb_q.delete();
      end else if (imem_req && imem_ready) begin
        e.instr = mem_word(pc);
        e.pc    = pc;
        sb_q.push_back(e);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] r;
    reset = 1'b1;
    id_stall = 1'b0;
    flush = 1'b0;
    rdy_en = 1'b1;
    flush_tgt = 32'h0040_1000;
    tick();

    // Reset state
    sample(0, 0, 1);
    check("rst_req", imem_req, 0);
    check("rst_pc_we", pc_we, 0);
    check("rst_valid", if_id_valid, 0);
    check("rst_instr", if_id_instr, NopInstr);
    check("rst_pc", if_id_pc, ResetPc);
    check("rst_pc4", if_id_pc_plus4, ResetPc + 32'd4);
    tick();
    reset = 1'b0;

    // First fetch after reset
    sample(0, 0, 1);
    check("c1_req", imem_req, 1);
    check("c1_pc_we", pc_we, 1);
    check("c1_addr", imem_addr, 32'h0040_0000);
    check("c1_pc_plus4", pc_plus4, 32'h0040_0004);
    tick();
    sample(0, 0, 1);
    check("c2_valid", if_id_valid, 1);
    check("c2_instr", if_id_instr, 32'h2008_0005);
    check("c2_pc", if_id_pc, 32'h0040_0000);
    check("c2_pc4", if_id_pc_plus4, 32'h0040_0004);
    tick();

    // Three wait cycles
    for (int i = 0; i < 3; i++) begin
      sample(0, 0, 0);
      check("wait_pc_we", pc_we, 0);
      if (i > 0) check("wait_bubble", if_id_valid, 0);
      if (i > 0) check("wait_nop", if_id_instr, NopInstr);
      tick();
    end
    sample(0, 0, 1);
    check("ready_pc_we", pc_we, 1);
    tick();
    sample(0, 0, 0);
    check("ready_land", if_id_valid, 1);
    tick();

    // Stall against a valid IF/ID: word goes to the hold buffer
    sample(0, 0, 1);
    tick();
    sample(1, 0, 1);
    check("stall_pc_we", pc_we, 1);
    check("stall_req", imem_req, 1);
    tick();
    for (int i = 0; i < 2; i++) begin
      sample(1, 0, 1);
      check("hold_req", imem_req, 0);
      check("hold_pc_we", pc_we, 0);
      check("hold_valid", if_id_valid, 1);
      check("hold_ifid_pc", if_id_pc, sb_q[0].pc);
      tick();
    end
    sample(0, 0, 1);
    check("unstall_req", imem_req, 0);
    tick();
    sample(0, 0, 1);
    check("held_valid", if_id_valid, 1);
    tick();

    // Flush together with a returned word
    sample(0, 1, 1);
    check("flush_pc_we", pc_we, 1);
    tick();
    sample(0, 0, 0);
    check("flush_valid", if_id_valid, 0);
    check("flush_addr", imem_addr, 32'h0040_1000);
    tick();

    // Flush while holding
    sample(0, 0, 1);
    tick();
    sample(1, 0, 1);
    tick();
    sample(1, 1, 0);
    check("hflush_pc_we", pc_we, 1);
    tick();
    sample(0, 0, 0);
    check("hflush_valid", if_id_valid, 0);
    check("hflush_req", imem_req, 1);
    tick();

    // PC+4 wrap
    flush_tgt = 32'hFFFF_FFFC;
    sample(0, 1, 0);
    tick();
    sample(0, 0, 1);
    check("wrap_pc_plus4", pc_plus4, 32'h0000_0000);
    tick();
    sample(0, 0, 0);
    check("wrap_ifid_pc4", if_id_pc_plus4, 32'h0000_0000);
    tick();

    // Reset during HOLD drops the held word
    sample(0, 0, 1);
    tick();
    sample(1, 0, 1);
    tick();
    reset = 1'b1;
    sample(1, 0, 1);
    check("rhold_req", imem_req, 0);
    tick();
    reset = 1'b0;
    sample(0, 0, 0);
    check("rhold_valid", if_id_valid, 0);
    check("rhold_pc", if_id_pc, ResetPc);
    check("rhold_fetch_req", imem_req, 1);
    tick();

    // Zero-wait throughput
    for (int i = 0; i < 8; i++) begin
      sample(0, 0, 1);
      check("tput_pc_we", pc_we, 1);
      if (i > 0) check("tput_valid", if_id_valid, 1);
      tick();
    end

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      r = $urandom;
      flush_tgt = {r[31:2], 2'b00};
      sample($urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0,
             $urandom_range(0, 3) != 0);
      tick();
    end

    // Drain
    for (int i = 0; i < 10 && sb_q.size() != 0; i++) begin
      sample(0, 0, 0);
      tick();
    end
    check("sb_drain", sb_q.size(), 0);

`ifdef FETCH_PERF_EN
    reset = 1'b1;
    sample(0, 0, 0);
    tick();
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      sample(0, 0, 1);
      tick();
    end
    for (int i = 0; i < 4; i++) begin
      sample(0, 0, 0);
      tick();
    end
    sample(0, 0, 0);
    check("perf_fetch_count", fetch_count, 32'd10);
    check("perf_wait_cycles", wait_cycles, 32'd4);
    tick();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the pipelined MIPS core. It sits directly downstream of the program counter: it presents the current PC to instruction memory, waits for the ready handshake, and loads the fetched word into the IF/ID pipeline register. It drives the PC's write enable so the PC advances only when an instruction is accepted or a redirect occurs. It absorbs decode stalls with a one-entry hold buffer and squashes on flush.

## Interface
Parameters:
- RESET_PC, 32'h00400000, PC value held in if_id_pc after reset
- NOP_INSTR, 32'h00000000, instruction word driven when the IF/ID register holds a bubble

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high
- pc  in  32  current PC from the program counter
- pc_we  out  1  write enable to the program counter
- pc_plus4  out  32  pc + 4 (combinational, mod 2^32), feeds the next-PC mux
- imem_req  out  1  fetch request
- imem_addr  out  32  fetch address, equal to pc
- imem_ready  in  1  imem_rdata is valid this cycle
- imem_rdata  in  32  fetched instruction
- id_stall  in  1  decode cannot accept a new IF/ID value
- flush  in  1  redirect or squash (branch, jump, or exception)
- if_id_valid  out  1  IF/ID holds a real instruction
- if_id_instr  out  32  IF/ID instruction
- if_id_pc  out  32  IF/ID instruction address
- if_id_pc_plus4  out  32  IF/ID address + 4

## Operation
- Acceptance rule: IF/ID may load when `!(id_stall && if_id_valid)`. A stall against a bubble is ignored.
- FSM states: FETCH and HOLD.
- FETCH behaviour:
  - imem_req=1 and imem_addr=pc.
  - flush has priority: pc_we=1, any imem_rdata is discarded, if_id_valid<=0, state stays FETCH. The outstanding request is withdrawn; imem keeps no state across an address change.
  - imem_ready with IF/ID able to load: load {imem_rdata, pc, pc+4} into IF/ID, if_id_valid<=1, pc_we=1.
  - imem_ready with IF/ID blocked: capture {imem_rdata, pc, pc+4} into the hold buffer, pc_we=1, go to HOLD.
  - No imem_ready: pc_we=0. If IF/ID can load, if_id_valid<=0 (bubble). Otherwise IF/ID is unchanged.
- HOLD behaviour:
  - imem_req=0 and pc_we=0, except on flush.
  - flush: drop the hold buffer, if_id_valid<=0, pc_we=1, go to FETCH.
  - id_stall deasserted: move the hold buffer into IF/ID, if_id_valid<=1, go to FETCH.
  - Otherwise stay in HOLD with IF/ID unchanged.
- When if_id_valid=0, if_id_instr reads NOP_INSTR.
- pc_plus4 and all +4 arithmetic is 32-bit and wraps at 32'hFFFFFFFC → 0.

## Timing
- Reset values: state=FETCH, if_id_valid=0, if_id_instr=NOP_INSTR, if_id_pc=RESET_PC, if_id_pc_plus4=RESET_PC+4, hold buffer cleared.
- While reset is high: imem_req=0 and pc_we=0.
- pc_we, imem_req and imem_addr are combinational from state, flush, imem_ready, id_stall and if_id_valid. The PC updates on the same edge that IF/ID or the hold buffer loads.
- Latency: imem_ready in cycle N gives if_id_valid=1 with that word in cycle N+1.
- Throughput: with zero-wait memory (imem_ready tied high), one instruction per cycle.
- Simultaneous events:
  - flush beats imem_ready, id_stall and HOLD.
  - Reset mid-HOLD discards the held instruction.
- The hold buffer is exactly one deep. A second fetch is never issued while in HOLD.

## Configuration
- FETCH_PERF_EN defined: adds output ports fetch_count[31:0] and wait_cycles[31:0].
  - fetch_count increments on each instruction accepted into IF/ID or the hold buffer, excluding flushed ones.
  - wait_cycles increments on each FETCH cycle with imem_req=1 and imem_ready=0.
  - Both counters reset to 0 and wrap at 2^32.
- FETCH_PERF_EN undefined: neither port nor either counter exists; all other behaviour is identical.

## Test plan
- Reset release with pc=32'h00400000 and imem_ready=1, imem_rdata=32'h20080005:
  - Cycle 1: imem_req=1, pc_we=1.
  - Cycle 2: if_id_valid=1, if_id_instr=32'h20080005, if_id_pc=32'h00400000, if_id_pc_plus4=32'h00400004.
- imem_ready low for 3 cycles: pc_we=0 for those 3 cycles, if_id_valid=0 after the first edge, and the word lands one cycle after ready rises.
- id_stall=1 with if_id_valid=1 while imem_ready=1:
  - pc_we=1, state goes to HOLD, IF/ID unchanged, and imem_req=0 while the stall lasts.
  - id_stall drop: the held word appears in IF/ID on the next edge.
- flush together with imem_ready=1: pc_we=1, if_id_valid=0 on the next edge, and the returned word never appears in IF/ID.
- flush while in HOLD: held word dropped, state returns to FETCH, if_id_valid=0.
- With FETCH_PERF_EN: 10 zero-wait fetches followed by 4 wait cycles give fetch_count=10 and wait_cycles=4.
